rename_operand_fetch: RTL and testbench
=======================================

// Module: rename_operand_fetch
// PURPOSE
//  Stage directly downstream of the front-end RAT.
//  Takes renamed sources per issue slot:
//   - tag: PRF index or ROB id
//   - type bit: 1 = PRF, 0 = ROB
//  Resolves each source to a value or a pending ROB tag, using the PRF read,
//  ROB completed-entry read and the CDB. Holds the bundle in a one-entry
//  valid/ready stage register that feeds dispatch to the reservation stations.
// PARAMETERS
//  ISSUE_W   2   slots per bundle; matches ISSUE_WIDTH_MAX
//  NSRC      2   sources per slot; matches NUM_SRCS
//  XLEN      32  operand data width
//  CDB_N     2   CDB broadcast ports
// PORTS
//  clk               in   1                           clock, single domain
//  rst               in   1                           asynchronous, active-high reset
//  instr_val_ar      in   ISSUE_W                     slot valid from RAT stage
//  src_renamed_ar    in   ISSUE_W*NSRC*RAT_RENAME_DATA_WIDTH   renamed source tag
//  src_data_type_ar  in   ISSUE_W*NSRC                1 = PRF index, 0 = ROB id
//  robid_is          in   ISSUE_W*ROB_SIZE_CLOG       ROB id of each slot
//  ar_ready          out  1                           stage can accept a bundle
//  prf_raddr         out  ISSUE_W*NSRC*SRC_LEN        PRF read address; data returns same cycle
//  prf_rdata         in   ISSUE_W*NSRC*XLEN           PRF read data
//  rob_raddr         out  ISSUE_W*NSRC*ROB_SIZE_CLOG  ROB result read index
//  rob_rdone         in   ISSUE_W*NSRC                ROB entry has completed
//  rob_rdata         in   ISSUE_W*NSRC*XLEN           ROB entry result
//  cdb_val           in   CDB_N                       CDB broadcast valid
//  cdb_robid         in   CDB_N*ROB_SIZE_CLOG         CDB ROB id
//  cdb_data          in   CDB_N*XLEN                  CDB result
//  branch_clear_id   in   1                           mispredict flush
//  ds_val            out  ISSUE_W                     slot valid to dispatch
//  ds_ready          in   1                           dispatch accepts the whole bundle
//  ds_src_rdy        out  ISSUE_W*NSRC                operand value present
//  ds_src_data       out  ISSUE_W*NSRC*XLEN           operand value; 0 when not ready
//  ds_src_tag        out  ISSUE_W*NSRC*ROB_SIZE_CLOG  pending ROB tag
//  ds_robid          out  ISSUE_W*ROB_SIZE_CLOG       ROB id of each slot
// BEHAVIOUR
//  - Reset (async, rst=1): all ds_val, ds_src_rdy, ds_src_data, ds_src_tag and ds_robid are 0.
//  - ar_ready = ~occ | ds_ready, where occ = |ds_val.
//  - Handshakes:
//     - Accept: ar_ready & |instr_val_ar. Bundle is registered at the next edge.
//     - Latency is 1 cycle.
//     - Dispatch: occ & ds_ready. Accept and dispatch in the same cycle is full-throughput replacement.
//     - Dispatch is all-or-nothing per bundle; no partial drain.
//  - Read addresses are driven combinationally from the *_ar inputs using the low bits of each tag.
//  - Source resolution at capture, highest priority first:
//     - PRF type, index 0 (x0): rdy=1, data=0.
//     - PRF type: rdy=1, data=prf_rdata.
//     - ROB type with CDB match (cdb_val[k] & cdb_robid[k]==tag): rdy=1, data=cdb_data[k]; lowest k wins.
//     - ROB type with rob_rdone: rdy=1, data=rob_rdata.
//     - Otherwise: rdy=0, tag kept, data=0.
//  - ds_src_tag always carries the ROB tag, even when rdy=1.
//  - Invalid slots register ds_val=0; their src fields are don't-care but driven 0.
//  - Flush: branch_clear_id=1 clears every ds_val at the next edge and drops any bundle
//    accepted that cycle. Flush wins over accept and hold. ar_ready is unaffected.
//  - Hold: occ & ~ds_ready keeps every field stable, except CDB snoop (see CONFIGURATION).
//  - Wrap-around: ROB id compare is equality only; no age math in this block.
// CONFIGURATION
//  `OPFETCH_HOLD_SNOOP_EN` defined:
//   - While occupied, each rdy=0 source compares against the CDB every cycle.
//   - On a match: rdy<=1, data<=cdb_data (lowest k wins), even while ds_ready=0.
//   - A match in the dispatch cycle is not reflected; the RS snoops the CDB from then on.
//  Not defined:
//   - Sources are resolved only at capture.
//   - Held pending sources stay rdy=0 until dispatched.
// STRUCTURE
//  Shared package (rtl_constants):
//   - opf_src_t {rdy, tag[ROB_SIZE_CLOG], data[XLEN]}
//   - opf_slot_t {val, robid, src[NSRC]}
//   - XLEN, CDB_N
//  Sub-module opf_src_resolve (combinational, instanced ISSUE_W*NSRC times): priority mux + CDB match.
//  Top level holds the stage register, handshake, flush and snoop logic.
// TESTING
//  - Reset mid-bundle: occ with ds_ready=0, assert rst -> ds_val=0 immediately (async); ar_ready=1 after release.
//  - Slot0 rs1 PRF idx 5 (prf_rdata=0xA5) and rs2 x0 -> next cycle ds_src_rdy=11,
//    data 0xA5 and 0, ds_val[0]=1.
//  - Slot1 rs1 ROB tag 7; cdb_val[1]=1, cdb_robid[1]=7, cdb_data 0x33; also rob_rdone=1 with 0x99
//    -> data 0x33, rdy=1.
//  - Pending tag 9, ds_ready=0 for 3 cycles, CDB broadcasts 9/0x44 in cycle 2
//    -> with _EN: rdy=1, data 0x44 from cycle 3; without: rdy=0.
//  - branch_clear_id with occ=1 and a new bundle offered -> ds_val=00 next cycle; the new bundle never appears.
//  - Back-to-back bundles with ds_ready=1 every cycle -> one dispatch per cycle, ar_ready held at 1.

Source files
------------

// File: rtl/rename_operand_fetch_pkg.sv
// rtl/rename_operand_fetch_pkg.sv - shared widths, operand/slot structs and CDB lookup for operand fetch
package rename_operand_fetch_pkg;

    localparam int ISSUE_W               = 2;
    localparam int NSRC                  = 2;
    localparam int XLEN                  = 32;
    localparam int CDB_N                 = 2;
    localparam int ROB_SIZE_CLOG         = 4;
    localparam int SRC_LEN               = 6;
    localparam int RAT_RENAME_DATA_WIDTH = 6;

    typedef struct packed {
        logic                     rdy;
        logic [ROB_SIZE_CLOG-1:0] tag;
        logic [XLEN-1:0]          data;
    } opf_src_t;

    typedef struct packed {
        logic                     val;
        logic [ROB_SIZE_CLOG-1:0] robid;
        opf_src_t [NSRC-1:0]      src;
    } opf_slot_t;

    typedef struct packed {
        logic            hit;
        logic [XLEN-1:0] data;
    } cdb_hit_t;

    // Scans from the highest port down so the lowest matching port wins.
    function automatic cdb_hit_t cdb_lookup(
        input logic [ROB_SIZE_CLOG-1:0]       tag,
        input logic [CDB_N-1:0]               val,
        input logic [CDB_N*ROB_SIZE_CLOG-1:0] robid,
        input logic [CDB_N*XLEN-1:0]          data
    );
        cdb_hit_t r;
        r = '0;
        for (int k = CDB_N - 1; k >= 0; k--) begin
            if (val[k] && robid[k*ROB_SIZE_CLOG +: ROB_SIZE_CLOG] == tag) begin
                r.hit  = 1'b1;
                r.data = data[k*XLEN +: XLEN];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rename_operand_fetch_if.sv
// rtl/rename_operand_fetch_if.sv - RAT-side, register-read, CDB and dispatch signals of operand fetch
interface rename_operand_fetch_if;
    import rename_operand_fetch_pkg::*;

    logic [ISSUE_W-1:0]                            instr_val_ar;
    logic [ISSUE_W*NSRC*RAT_RENAME_DATA_WIDTH-1:0] src_renamed_ar;
    logic [ISSUE_W*NSRC-1:0]                       src_data_type_ar;
    logic [ISSUE_W*ROB_SIZE_CLOG-1:0]              robid_is;
    logic                                          ar_ready;
    logic [ISSUE_W*NSRC*SRC_LEN-1:0]               prf_raddr;
    logic [ISSUE_W*NSRC*XLEN-1:0]                  prf_rdata;
    logic [ISSUE_W*NSRC*ROB_SIZE_CLOG-1:0]         rob_raddr;
    logic [ISSUE_W*NSRC-1:0]                       rob_rdone;
    logic [ISSUE_W*NSRC*XLEN-1:0]                  rob_rdata;
    logic [CDB_N-1:0]                              cdb_val;
    logic [CDB_N*ROB_SIZE_CLOG-1:0]                cdb_robid;
    logic [CDB_N*XLEN-1:0]                         cdb_data;
    logic                                          branch_clear_id;
    logic [ISSUE_W-1:0]                            ds_val;
    logic                                          ds_ready;
    logic [ISSUE_W*NSRC-1:0]                       ds_src_rdy;
    logic [ISSUE_W*NSRC*XLEN-1:0]                  ds_src_data;
    logic [ISSUE_W*NSRC*ROB_SIZE_CLOG-1:0]         ds_src_tag;
    logic [ISSUE_W*ROB_SIZE_CLOG-1:0]              ds_robid;

    modport slave (
        input  instr_val_ar, src_renamed_ar, src_data_type_ar, robid_is,
        input  prf_rdata, rob_rdone, rob_rdata, cdb_val, cdb_robid, cdb_data,
        input  branch_clear_id, ds_ready,
        output ar_ready, prf_raddr, rob_raddr,
        output ds_val, ds_src_rdy, ds_src_data, ds_src_tag, ds_robid
    );

    modport master (
        output instr_val_ar, src_renamed_ar, src_data_type_ar, robid_is,
        output prf_rdata, rob_rdone, rob_rdata, cdb_val, cdb_robid, cdb_data,
        output branch_clear_id, ds_ready,
        input  ar_ready, prf_raddr, rob_raddr,
        input  ds_val, ds_src_rdy, ds_src_data, ds_src_tag, ds_robid
    );

endinterface

// File: rtl/rename_operand_fetch_src_resolve.sv
// rtl/rename_operand_fetch_src_resolve.sv - opf_src_resolve: one source's x0/PRF/CDB/ROB priority mux
module opf_src_resolve
    import rename_operand_fetch_pkg::*;
(
    input  logic                             typ,
    input  logic [RAT_RENAME_DATA_WIDTH-1:0] tag,
    input  logic [XLEN-1:0]                  prf_rdata,
    input  logic                             rob_rdone,
    input  logic [XLEN-1:0]                  rob_rdata,
    input  logic [CDB_N-1:0]                 cdb_val,
    input  logic [CDB_N*ROB_SIZE_CLOG-1:0]   cdb_robid,
    input  logic [CDB_N*XLEN-1:0]            cdb_data,
    output opf_src_t                         src
);

    cdb_hit_t hit;

    always_comb begin
        hit      = cdb_lookup(tag[ROB_SIZE_CLOG-1:0], cdb_val, cdb_robid, cdb_data);
        src      = '0;
        src.tag  = tag[ROB_SIZE_CLOG-1:0];
        if (typ) begin
            src.rdy  = 1'b1;
            src.data = (tag[SRC_LEN-1:0] == '0) ? '0 : prf_rdata;
        end else if (hit.hit) begin
            src.rdy  = 1'b1;
            src.data = hit.data;
        end else if (rob_rdone) begin
            src.rdy  = 1'b1;
            src.data = rob_rdata;
        end
    end

endmodule

// File: rtl/rename_operand_fetch.sv
// rtl/rename_operand_fetch.sv - operand fetch stage register after the RAT
// OPFETCH_HOLD_SNOOP_EN: held pending sources pick up CDB results while stalled.
module rename_operand_fetch
    import rename_operand_fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    rename_operand_fetch_if.slave bus
);

    opf_slot_t [ISSUE_W-1:0]      slots_q, slots_d, cap;
    opf_src_t  [ISSUE_W*NSRC-1:0] res;
    logic                         occ, accept;

    assign occ          = |{slots_q[1].val, slots_q[0].val};
    assign bus.ar_ready = ~occ | bus.ds_ready;
    assign accept       = bus.ar_ready & (|bus.instr_val_ar);

    always_comb begin
        bus.prf_raddr = '0;
        bus.rob_raddr = '0;
        for (int n = 0; n < ISSUE_W*NSRC; n++) begin
            bus.prf_raddr[n*SRC_LEN +: SRC_LEN] =
                bus.src_renamed_ar[n*RAT_RENAME_DATA_WIDTH +: SRC_LEN];
            bus.rob_raddr[n*ROB_SIZE_CLOG +: ROB_SIZE_CLOG] =
                bus.src_renamed_ar[n*RAT_RENAME_DATA_WIDTH +: ROB_SIZE_CLOG];
        end
    end

    for (genvar n = 0; n < ISSUE_W*NSRC; n++) begin : g_res
        opf_src_resolve u_res (
            .typ       (bus.src_data_type_ar[n]),
            .tag       (bus.src_renamed_ar[n*RAT_RENAME_DATA_WIDTH +: RAT_RENAME_DATA_WIDTH]),
            .prf_rdata (bus.prf_rdata[n*XLEN +: XLEN]),
            .rob_rdone (bus.rob_rdone[n]),
            .rob_rdata (bus.rob_rdata[n*XLEN +: XLEN]),
            .cdb_val   (bus.cdb_val),
            .cdb_robid (bus.cdb_robid),
            .cdb_data  (bus.cdb_data),
            .src       (res[n])
        );
    end

    // Invalid slots capture all-zero so downstream never sees stale fields.
    always_comb begin
        cap = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (bus.instr_val_ar[i]) begin
                cap[i].val   = 1'b1;
                cap[i].robid = bus.robid_is[i*ROB_SIZE_CLOG +: ROB_SIZE_CLOG];
                for (int j = 0; j < NSRC; j++) begin
                    cap[i].src[j] = res[i*NSRC+j];
                end
            end
        end
    end

    always_comb begin
`ifdef OPFETCH_HOLD_SNOOP_EN
        cdb_hit_t h;
`endif
        slots_d = slots_q;
`ifdef OPFETCH_HOLD_SNOOP_EN
        h = '0;
        if (occ && !bus.ds_ready) begin
            for (int i = 0; i < ISSUE_W; i++) begin
                for (int j = 0; j < NSRC; j++) begin
                    h = cdb_lookup(slots_q[i].src[j].tag, bus.cdb_val, bus.cdb_robid, bus.cdb_data);
                    if (slots_q[i].val && !slots_q[i].src[j].rdy && h.hit) begin
                        slots_d[i].src[j].rdy  = 1'b1;
                        slots_d[i].src[j].data = h.data;
                    end
                end
            end
        end
`endif
        if (accept) begin
            slots_d = cap;
        end else if (occ && bus.ds_ready) begin
            for (int i = 0; i < ISSUE_W; i++) slots_d[i].val = 1'b0;
        end
        // Flush overrides both accept and hold.
        if (bus.branch_clear_id) begin
            for (int i = 0; i < ISSUE_W; i++) slots_d[i].val = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) slots_q <= '0;
        else     slots_q <= slots_d;
    end

    always_comb begin
        bus.ds_val      = '0;
        bus.ds_src_rdy  = '0;
        bus.ds_src_data = '0;
        bus.ds_src_tag  = '0;
        bus.ds_robid    = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            bus.ds_val[i]                                   = slots_q[i].val;
            bus.ds_robid[i*ROB_SIZE_CLOG +: ROB_SIZE_CLOG]  = slots_q[i].robid;
            for (int j = 0; j < NSRC; j++) begin
                bus.ds_src_rdy[i*NSRC+j]                                   = slots_q[i].src[j].rdy;
                bus.ds_src_data[(i*NSRC+j)*XLEN +: XLEN]                   = slots_q[i].src[j].data;
                bus.ds_src_tag[(i*NSRC+j)*ROB_SIZE_CLOG +: ROB_SIZE_CLOG]  = slots_q[i].src[j].tag;
            end
        end
    end

endmodule

// File: tb/tb_rename_operand_fetch.sv
// tb/tb_rename_operand_fetch.sv - scoreboard bench for rename_operand_fetch
module tb_rename_operand_fetch;
    import rename_operand_fetch_pkg::*;

    typedef struct packed {
        logic [ISSUE_W-1:0]                    val;
        logic [ISSUE_W*NSRC-1:0]               rdy;
        logic [ISSUE_W*NSRC*XLEN-1:0]          data;
        logic [ISSUE_W*NSRC*ROB_SIZE_CLOG-1:0] tag;
        logic [ISSUE_W*ROB_SIZE_CLOG-1:0]      robid;
    } exp_t;

`ifdef OPFETCH_HOLD_SNOOP_EN
    localparam bit SNOOP = 1'b1;
`else
    localparam bit SNOOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rename_operand_fetch_if bus ();
    rename_operand_fetch dut (.clk(clk), .rst(rst), .bus(bus));

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t xslot(input exp_t e, input int i, input logic [3:0] rid);
        e.val[i]           = 1'b1;
        e.robid[i*4 +: 4]  = rid;
        return e;
    endfunction

    function automatic exp_t xsrc(input exp_t e, input int n, input logic r,
                                  input logic [31:0] d, input logic [3:0] t);
        e.rdy[n]          = r;
        e.data[n*32 +: 32] = d;
        e.tag[n*4 +: 4]    = t;
        return e;
    endfunction

    task automatic clr_in();
        bus.instr_val_ar     = '0;
        bus.src_renamed_ar   = '0;
        bus.src_data_type_ar = '0;
        bus.robid_is         = '0;
        bus.prf_rdata        = '0;
        bus.rob_rdone        = '0;
        bus.rob_rdata        = '0;
        bus.cdb_val          = '0;
        bus.cdb_robid        = '0;
        bus.cdb_data         = '0;
        bus.branch_clear_id  = 1'b0;
    endtask

    task automatic set_src(input int n, input logic typ, input logic [5:0] tag);
        bus.src_data_type_ar[n]    = typ;
        bus.src_renamed_ar[n*6 +: 6] = tag;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr_in();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (|bus.ds_val) && bus.ds_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dispatch actual_val=%0h expected=none", bus.ds_val);
            end else begin
                e = sbq.pop_front();
                chk("ds_val",      bus.ds_val,      e.val);
                chk("ds_src_rdy",  bus.ds_src_rdy,  e.rdy);
                chk("ds_src_data", bus.ds_src_data, e.data);
                chk("ds_src_tag",  bus.ds_src_tag,  e.tag);
                chk("ds_robid",    bus.ds_robid,    e.robid);
            end
        end
    end

    initial begin
        exp_t e;
        clr_in();
        bus.ds_ready = 1'b0;
        #1;
        chk("rst_ds_val",   bus.ds_val,      0);
        chk("rst_rdy",      bus.ds_src_rdy,  0);
        chk("rst_data",     bus.ds_src_data, 0);
        chk("rst_tag",      bus.ds_src_tag,  0);
        chk("rst_robid",    bus.ds_robid,    0);
        chk("rst_ar_ready", bus.ar_ready,    1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // slot0: PRF 5 and x0
        bus.ds_ready = 1'b1;
        bus.instr_val_ar = 2'b01;
        bus.robid_is[3:0] = 4'd1;
        set_src(0, 1'b1, 6'd5);  bus.prf_rdata[31:0]  = 32'hA5;
        set_src(1, 1'b1, 6'd0);  bus.prf_rdata[63:32] = 32'h77;
        #1;
        chk("prf_raddr0", bus.prf_raddr[5:0], 5);
        chk("rob_raddr0", bus.rob_raddr[3:0], 5);
        e = '0; e = xslot(e, 0, 4'd1);
        e = xsrc(e, 0, 1'b1, 32'hA5, 4'd5);
        e = xsrc(e, 1, 1'b1, 32'h0, 4'd0);
        sbq.push_back(e);
        step();

        // pending ROB, rob_rdone, CDB beats rob_rdone, PRF
        bus.instr_val_ar = 2'b11;
        bus.robid_is = {4'd8, 4'd2};
        set_src(0, 1'b0, 6'd2);
        set_src(1, 1'b0, 6'd6);  bus.rob_rdone[1] = 1'b1; bus.rob_rdata[63:32] = 32'h66;
        set_src(2, 1'b0, 6'd7);  bus.rob_rdone[2] = 1'b1; bus.rob_rdata[95:64] = 32'h99;
        set_src(3, 1'b1, 6'd9);  bus.prf_rdata[127:96] = 32'h1234;
        bus.cdb_val = 2'b10; bus.cdb_robid[7:4] = 4'd7; bus.cdb_data[63:32] = 32'h33;
        e = '0; e = xslot(e, 0, 4'd2); e = xslot(e, 1, 4'd8);
        e = xsrc(e, 0, 1'b0, 32'h0,    4'd2);
        e = xsrc(e, 1, 1'b1, 32'h66,   4'd6);
        e = xsrc(e, 2, 1'b1, 32'h33,   4'd7);
        e = xsrc(e, 3, 1'b1, 32'h1234, 4'd9);
        sbq.push_back(e);
        step();

        // two CDB ports match: lowest port wins
        bus.instr_val_ar = 2'b01;
        bus.robid_is[3:0] = 4'd3;
        set_src(0, 1'b0, 6'd4);
        set_src(1, 1'b1, 6'd0);
        bus.cdb_val = 2'b11; bus.cdb_robid = {4'd4, 4'd4}; bus.cdb_data = {32'h22, 32'h11};
        e = '0; e = xslot(e, 0, 4'd3);
        e = xsrc(e, 0, 1'b1, 32'h11, 4'd4);
        e = xsrc(e, 1, 1'b1, 32'h0,  4'd0);
        sbq.push_back(e);
        step();
        repeat (2) @(posedge clk);
        #1;

        // pending tag 9 held three cycles, CDB 9/0x44 in the second
        bus.ds_ready = 1'b0;
        bus.instr_val_ar = 2'b01;
        bus.robid_is[3:0] = 4'd5;
        set_src(0, 1'b0, 6'd9);
        set_src(1, 1'b1, 6'd0);
        e = '0; e = xslot(e, 0, 4'd5);
        e = xsrc(e, 0, SNOOP, SNOOP ? 32'h44 : 32'h0, 4'd9);
        e = xsrc(e, 1, 1'b1, 32'h0, 4'd0);
        sbq.push_back(e);
        step();
        chk("hold_ar_ready", bus.ar_ready, 0);
        step();
        bus.cdb_val = 2'b01; bus.cdb_robid[3:0] = 4'd9; bus.cdb_data[31:0] = 32'h44;
        step();
        chk("snoop_rdy",  bus.ds_src_rdy[0], SNOOP);
        chk("snoop_data", bus.ds_src_data[31:0], SNOOP ? 32'h44 : 32'h0);
        step();
        bus.ds_ready = 1'b1;
        step();
        chk("post_disp_val", bus.ds_val, 0);

        // flush while occupied and stalled, new bundle offered
        bus.ds_ready = 1'b0;
        bus.instr_val_ar = 2'b10;
        set_src(2, 1'b1, 6'd3); bus.prf_rdata[95:64] = 32'hDEAD;
        step();
        bus.instr_val_ar = 2'b11;
        set_src(0, 1'b1, 6'd1); bus.prf_rdata[31:0] = 32'hBAD0;
        bus.branch_clear_id = 1'b1;
        #1;
        chk("flush_ar_ready_occ", bus.ar_ready, 0);
        step();
        chk("flush_val", bus.ds_val, 0);
        chk("flush_ar_ready_after", bus.ar_ready, 1);

        // flush on empty stage: accepted bundle dropped, next bundle intact
        bus.ds_ready = 1'b1;
        bus.instr_val_ar = 2'b01;
        set_src(0, 1'b1, 6'd2); bus.prf_rdata[31:0] = 32'hBAD1;
        bus.branch_clear_id = 1'b1;
        #1;
        chk("flush_ar_ready_empty", bus.ar_ready, 1);
        step();
        chk("flush_drop_val", bus.ds_val, 0);
        bus.instr_val_ar = 2'b01;
        bus.robid_is[3:0] = 4'd12;
        set_src(0, 1'b1, 6'd17); bus.prf_rdata[31:0] = 32'hC0C0;
        set_src(1, 1'b1, 6'd0);
        e = '0; e = xslot(e, 0, 4'd12);
        e = xsrc(e, 0, 1'b1, 32'hC0C0, 4'd1);
        e = xsrc(e, 1, 1'b1, 32'h0, 4'd0);
        sbq.push_back(e);
        step();
        @(posedge clk);
        #1;

        // back-to-back full-throughput bundles
        for (int k = 0; k < 4; k++) begin
            bus.instr_val_ar = 2'b11;
            bus.robid_is = {4'(k + 8), 4'(k)};
            set_src(0, 1'b1, 6'(k + 1)); bus.prf_rdata[31:0] = 32'h100 + k;
            set_src(1, 1'b1, 6'd0);
            set_src(2, 1'b1, 6'd0);
            set_src(3, 1'b1, 6'd0);
            e = '0; e = xslot(e, 0, 4'(k)); e = xslot(e, 1, 4'(k + 8));
            e = xsrc(e, 0, 1'b1, 32'h100 + k, 4'(k + 1));
            e = xsrc(e, 1, 1'b1, 32'h0, 4'd0);
            e = xsrc(e, 2, 1'b1, 32'h0, 4'd0);
            e = xsrc(e, 3, 1'b1, 32'h0, 4'd0);
            sbq.push_back(e);
            #1;
            chk("b2b_ar_ready", bus.ar_ready, 1);
            step();
        end
        @(posedge clk);
        #1;
        chk("b2b_drained", bus.ds_val, 0);

        // async reset while a bundle is held
        bus.ds_ready = 1'b0;
        bus.instr_val_ar = 2'b01;
        set_src(0, 1'b1, 6'd7); bus.prf_rdata[31:0] = 32'h5A;
        step();
        chk("pre_rst_val", bus.ds_val, 2'b01);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_val",  bus.ds_val, 0);
        chk("async_rst_data", bus.ds_src_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_release_ar_ready", bus.ar_ready, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
